// File: rtl/spi_xip_bridge.sv
// spi_xip_bridge: memory-mapped read front-end for spi_core.
// Turns one valid/ready word-read request into the APB register sequence that
// programs a flash read. It then polls STATUS, pops one RXFIFO word and returns it.
//
// Ports
//   HCLK, HRESETn           clock, synchronous active-low reset
//   req_valid/ready/addr    read request (24-bit byte address, word aligned internally)
//   resp_valid/ready        response handshake
//   resp_data/resp_err      returned RXFIFO word, error flag (PSLVERR or poll timeout)
//   init_done               CLKDIV has been programmed after reset
//   PADDR..PENABLE          APB master outputs towards spi_core
//   PRDATA/PREADY/PSLVERR   APB slave responses
module spi_xip_bridge #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter logic [7:0]  CLK_DIV        = 8'd2,
  parameter logic [7:0]  RD_CMD         = 8'h03,
  parameter logic        QUAD           = 1'b0,
  parameter logic [15:0] DUMMY_CYC      = 16'd0,
  parameter int unsigned CS_SEL         = 2,
  parameter int unsigned POLL_LIMIT     = 4096
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [23:0]               req_addr,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [31:0]               resp_data,
  output logic                      resp_err,
  output logic                      init_done,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam int unsigned AW    = APB_ADDR_WIDTH;
  localparam int unsigned CFG_W = AW + 33;
  localparam int unsigned CNT_W = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;

  localparam logic [AW-1:0] A_STATUS = AW'(8'h00);
  localparam logic [AW-1:0] A_CLKDIV = AW'(8'h04);
  localparam logic [AW-1:0] A_SPICMD = AW'(8'h08);
  localparam logic [AW-1:0] A_SPIADR = AW'(8'h0C);
  localparam logic [AW-1:0] A_SPILEN = AW'(8'h10);
  localparam logic [AW-1:0] A_SPIDUM = AW'(8'h14);
  localparam logic [AW-1:0] A_RXFIFO = AW'(8'h20);

  localparam logic [3:0]  CSREG    = 4'(1 << CS_SEL);
  localparam logic [31:0] LEN_WORD = {16'd32, 2'b0, 6'd24, 2'b0, 6'd8};
  localparam logic [31:0] GO_WORD  = {20'h0, CSREG, 3'b0, 1'b0, 1'b0, QUAD, 1'b0, ~QUAD};

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_W_CMD, S_W_ADR, S_W_LEN, S_W_DUM, S_W_GO, S_POLL, S_RD_RX, S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [23:0]        addr_q, addr_d;
  logic [CNT_W-1:0]   poll_cnt_q, poll_cnt_d;
  logic               psel_d, penable_d, pwrite_d;
  logic [AW-1:0]      paddr_d;
  logic [31:0]        pwdata_d;
  logic               req_ready_d, resp_valid_d, resp_err_d, init_done_d;
  logic [31:0]        resp_data_d;
  logic               start_c;
  logic [CFG_W-1:0]   cfg_c;

  // {write, address, write data} of the APB access each state performs
  function automatic logic [CFG_W-1:0] acc_cfg(input state_t s, input logic [23:0] a);
    acc_cfg = '0;
    case (s)
      S_INIT:  acc_cfg = {1'b1, A_CLKDIV, {24'h0, CLK_DIV}};
      S_W_CMD: acc_cfg = {1'b1, A_SPICMD, {RD_CMD, 24'h0}};
      S_W_ADR: acc_cfg = {1'b1, A_SPIADR, {a, 8'h00}};
      S_W_LEN: acc_cfg = {1'b1, A_SPILEN, LEN_WORD};
      S_W_DUM: acc_cfg = {1'b1, A_SPIDUM, {16'h0, DUMMY_CYC}};
      S_W_GO:  acc_cfg = {1'b1, A_STATUS, GO_WORD};
      S_POLL:  acc_cfg = {1'b0, A_STATUS, 32'h0};
      S_RD_RX: acc_cfg = {1'b0, A_RXFIFO, 32'h0};
      default: acc_cfg = '0;
    endcase
  endfunction

  // Next-state and APB/handshake output logic
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    poll_cnt_d   = poll_cnt_q;
    psel_d       = PSEL;
    penable_d    = PENABLE;
    paddr_d      = PADDR;
    pwdata_d     = PWDATA;
    pwrite_d     = PWRITE;
    req_ready_d  = req_ready;
    resp_valid_d = resp_valid;
    resp_data_d  = resp_data;
    resp_err_d   = resp_err;
    init_done_d  = init_done;
    start_c      = 1'b0;
    cfg_c        = '0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          addr_d      = req_addr & 24'hFFFFFC;
          poll_cnt_d  = '0;
          req_ready_d = 1'b0;
          state_d     = S_W_CMD;
          start_c     = 1'b1;
        end
      end

      S_RESP: begin
        if (resp_ready && resp_valid) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = S_IDLE;
        end
      end

      default: begin
        if (!PSEL) begin
          // only reached in INIT right after reset; later accesses chain directly
          start_c = 1'b1;
        end else if (!PENABLE) begin
          penable_d = 1'b1;
        end else if (PREADY) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          if (state_q == S_INIT) begin
            init_done_d = 1'b1;
            req_ready_d = 1'b1;
            state_d     = S_IDLE;
          end else if (state_q == S_RD_RX) begin
            resp_data_d  = PRDATA;
            resp_err_d   = PSLVERR;
            resp_valid_d = 1'b1;
            state_d      = S_RESP;
          end else if (PSLVERR) begin
            resp_data_d  = '0;
            resp_err_d   = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = S_RESP;
          end else begin
            case (state_q)
              S_W_CMD: begin state_d = S_W_ADR; start_c = 1'b1; end
              S_W_ADR: begin state_d = S_W_LEN; start_c = 1'b1; end
              S_W_LEN: begin state_d = S_W_DUM; start_c = 1'b1; end
              S_W_DUM: begin state_d = S_W_GO;  start_c = 1'b1; end
              S_W_GO:  begin state_d = S_POLL;  start_c = 1'b1; end
              S_POLL: begin
                if (PRDATA[23:16] != 8'h00) begin
                  state_d = S_RD_RX;
                  start_c = 1'b1;
                end else if (poll_cnt_q == CNT_W'(POLL_LIMIT - 1)) begin
                  resp_data_d  = '0;
                  resp_err_d   = 1'b1;
                  resp_valid_d = 1'b1;
                  state_d      = S_RESP;
                end else begin
                  poll_cnt_d = poll_cnt_q + 1'b1;
                  start_c    = 1'b1;
                end
              end
              default: state_d = S_IDLE;
            endcase
          end
        end
      end
    endcase

    // a new access enters SETUP on the edge after the previous one completes
    if (start_c) begin
      cfg_c     = acc_cfg(state_d, addr_d);
      psel_d    = 1'b1;
      penable_d = 1'b0;
      {pwrite_d, paddr_d, pwdata_d} = cfg_c;
    end
  end

  // State and output registers
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q    <= S_INIT;
      addr_q     <= '0;
      poll_cnt_q <= '0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      PWRITE     <= 1'b0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      poll_cnt_q <= poll_cnt_d;
      PSEL       <= psel_d;
      PENABLE    <= penable_d;
      PADDR      <= paddr_d;
      PWDATA     <= pwdata_d;
      PWRITE     <= pwrite_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_data  <= resp_data_d;
      resp_err   <= resp_err_d;
      init_done  <= init_done_d;
    end
  end

endmodule

// File: tb/tb_spi_xip_bridge.sv
// tb_spi_xip_bridge: directed bench for spi_xip_bridge with an APB slave model
// and scoreboards for expected APB accesses and expected responses.
module tb_spi_xip_bridge;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        req_valid, req_ready;
  logic [23:0] req_addr;
  logic        resp_valid, resp_ready, resp_err, init_done;
  logic [31:0] resp_data;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA  = 32'h0;
  logic        PREADY  = 1'b0;
  logic        PSLVERR = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct packed { logic w; logic [11:0] a; logic [31:0] d; } apb_t;
  typedef struct packed { logic e; logic [31:0] d; } resp_t;
  apb_t  exp_apb[$];
  resp_t exp_resp[$];

  // slave model configuration
  int          wait_n     = 0;
  int          wcnt       = 0;
  logic [31:0] status_val = 32'h00010001;
  logic [31:0] rx_val     = 32'hDEADBEEF;
  logic        err_en     = 1'b0;
  logic [11:0] err_addr   = 12'h000;

  // APB outputs as seen during the previous cycle
  logic        s_psel = 1'b0, s_penable = 1'b0, s_pready = 1'b0, s_write = 1'b0;
  logic [11:0] s_addr  = 12'h0;
  logic [31:0] s_wdata = 32'h0;

  spi_xip_bridge #(.POLL_LIMIT(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_err(resp_err), .init_done(init_done),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // APB slave: logs completed accesses against the scoreboard, checks that an
  // access in progress keeps its address/data, then drives PREADY/PRDATA/PSLVERR.
  always @(negedge HCLK) begin : slave
    logic done;
    apb_t e;
    done = s_psel && s_penable && s_pready && HRESETn;
    if (done) begin
      chk("apb_expected", 32'(exp_apb.size() > 0), 32'd1);
      if (exp_apb.size() > 0) begin
        e = exp_apb.pop_front();
        chk("apb_write", 32'(s_write), 32'(e.w));
        chk("apb_addr", 32'(s_addr), 32'(e.a));
        if (e.w) chk("apb_wdata", s_wdata, e.d);
      end
    end else if (s_psel && HRESETn) begin
      chk("apb_psel_held", 32'(PSEL), 32'd1);
      chk("apb_penable", 32'(PENABLE), 32'd1);
      chk("apb_addr_stable", 32'(PADDR), 32'(s_addr));
      chk("apb_wdata_stable", PWDATA, s_wdata);
      chk("apb_write_stable", 32'(PWRITE), 32'(s_write));
    end

    if (PSEL && PENABLE) begin
      if (wcnt >= wait_n) begin
        PREADY  = 1'b1;
        PSLVERR = err_en && (PADDR == err_addr);
        PRDATA  = (PADDR == 12'h000) ? status_val :
                  (PADDR == 12'h020) ? rx_val : 32'h0;
      end else begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        wcnt++;
      end
    end else begin
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      wcnt    = 0;
    end

    s_psel    = PSEL;
    s_penable = PENABLE;
    s_pready  = PREADY;
    s_write   = PWRITE;
    s_addr    = PADDR;
    s_wdata   = PWDATA;
  end

  task automatic push_w(input logic [11:0] a, input logic [31:0] d);
    exp_apb.push_back({1'b1, a, d});
  endtask

  task automatic push_r(input logic [11:0] a);
    exp_apb.push_back({1'b0, a, 32'h0});
  endtask

  task automatic push_cmd_adr(input logic [23:0] a);
    push_w(12'h008, 32'h03000000);
    push_w(12'h00C, {a[23:2], 2'b00, 8'h00});
  endtask

  task automatic push_len_dum_go();
    push_w(12'h010, 32'h00201808);
    push_w(12'h014, 32'h00000000);
    push_w(12'h000, 32'h00000401);
  endtask

  // Issues one request (caller sits just after a falling edge with the DUT idle),
  // measures cycles from acceptance to resp_valid and completes the response.
  task automatic run_req(input logic [23:0] a, input int hold, output int lat);
    resp_t e;
    req_valid = 1'b1;
    req_addr  = a;
    lat       = -1;
    for (int n = 1; n <= 1000; n++) begin
      @(negedge HCLK);
      if (n == 1) begin
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        #1 req_valid = 1'b0;
      end
      if (resp_valid) begin
        lat = n - 1;
        break;
      end
    end
    chk("resp_seen", 32'(lat >= 0), 32'd1);
    if (lat >= 0) begin
      e = (exp_resp.size() != 0) ? exp_resp.pop_front() : '0;
      chk("resp_data", resp_data, e.d);
      chk("resp_err", 32'(resp_err), 32'(e.e));
      for (int i = 0; i < hold; i++) begin
        @(negedge HCLK);
        chk("resp_hold_valid", 32'(resp_valid), 32'd1);
        chk("resp_hold_data", resp_data, e.d);
      end
      #1 resp_ready = 1'b1;
      @(negedge HCLK);
      chk("resp_drop", 32'(resp_valid), 32'd0);
      chk("idle_ready", 32'(req_ready), 32'd1);
      #1 resp_ready = 1'b0;
    end else begin
      #1;
    end
  endtask

  initial begin
    int   lat;
    logic found;
    HRESETn    = 1'b0;
    req_valid  = 1'b0;
    req_addr   = 24'h0;
    resp_ready = 1'b0;

    // reset values
    repeat (3) @(negedge HCLK);
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_pwrite", 32'(PWRITE), 32'd0);
    chk("rst_paddr", 32'(PADDR), 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);

    // CLKDIV write after release, init_done on the third edge
    push_w(12'h004, 32'h00000002);
    #1 HRESETn = 1'b1;
    @(negedge HCLK);
    chk("init_done_c1", 32'(init_done), 32'd0);
    @(negedge HCLK);
    chk("init_done_c2", 32'(init_done), 32'd0);
    @(negedge HCLK);
    chk("init_done_c3", 32'(init_done), 32'd1);
    chk("init_req_ready", 32'(req_ready), 32'd1);
    repeat (5) @(negedge HCLK);
    chk("quiet_psel", 32'(PSEL), 32'd0);
    chk("init_apb_drained", 32'(exp_apb.size()), 32'd0);
    #1;

    // zero-wait read, data on first poll
    push_cmd_adr(24'h012347);
    push_len_dum_go();
    push_r(12'h000);
    push_r(12'h020);
    exp_resp.push_back({1'b0, 32'hDEADBEEF});
    run_req(24'h012347, 0, lat);
    chk("lat_zero_wait", 32'(lat), 32'd14);

    // three wait states on every access
    wait_n = 3;
    rx_val = 32'h13579BDF;
    push_cmd_adr(24'hABCDEF);
    push_len_dum_go();
    push_r(12'h000);
    push_r(12'h020);
    exp_resp.push_back({1'b0, 32'h13579BDF});
    run_req(24'hABCDEF, 0, lat);
    chk("lat_wait3", 32'(lat), 32'd35);
    wait_n = 0;

    // STATUS never reports data: poll timeout after 8 reads
    status_val = 32'h00000001;
    push_cmd_adr(24'h000100);
    push_len_dum_go();
    for (int i = 0; i < 8; i++) push_r(12'h000);
    exp_resp.push_back({1'b1, 32'h0});
    run_req(24'h000100, 0, lat);
    chk("lat_timeout", 32'(lat), 32'd26);
    status_val = 32'h00010001;

    // slave error on the SPIADR write aborts the sequence; response held 5 cycles
    err_en   = 1'b1;
    err_addr = 12'h00C;
    push_cmd_adr(24'h345678);
    exp_resp.push_back({1'b1, 32'h0});
    run_req(24'h345678, 5, lat);
    chk("lat_slverr", 32'(lat), 32'd4);
    err_en = 1'b0;

    // next request issued immediately after the response handshake
    rx_val = 32'hCAFEF00D;
    push_cmd_adr(24'h000004);
    push_len_dum_go();
    push_r(12'h000);
    push_r(12'h020);
    exp_resp.push_back({1'b0, 32'hCAFEF00D});
    run_req(24'h000004, 0, lat);
    chk("lat_back_to_back", 32'(lat), 32'd14);

    // reset asserted during the ACCESS phase of the STATUS go write
    push_cmd_adr(24'h00ABC0);
    push_w(12'h010, 32'h00201808);
    push_w(12'h014, 32'h00000000);
    req_valid = 1'b1;
    req_addr  = 24'h00ABC0;
    found     = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge HCLK);
      if (PSEL && PENABLE && PWRITE && (PADDR == 12'h000)) begin
        found = 1'b1;
        break;
      end
    end
    chk("go_access_found", 32'(found), 32'd1);
    #1;
    HRESETn   = 1'b0;
    req_valid = 1'b0;
    @(negedge HCLK);
    chk("abort_psel", 32'(PSEL), 32'd0);
    chk("abort_penable", 32'(PENABLE), 32'd0);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_init_done", 32'(init_done), 32'd0);
    push_w(12'h004, 32'h00000002);
    #1 HRESETn = 1'b1;
    repeat (3) @(negedge HCLK);
    chk("reinit_done", 32'(init_done), 32'd1);
    repeat (3) @(negedge HCLK);
    chk("final_apb_drained", 32'(exp_apb.size()), 32'd0);
    chk("final_resp_drained", 32'(exp_resp.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_xip_bridge.md
Name: spi_xip_bridge

Overview:
- Memory-mapped read front-end that sits directly upstream of spi_core and acts as the APB master on its register port.
- Turns a simple valid/ready word-read request into the APB register sequence that programs one flash read transaction, then polls, drains the RX FIFO and returns the word.
- Lets the CPU fetch or load from external SPI flash without any software driver.

Parameters:
- APB_ADDR_WIDTH, 12, width of the PADDR output; must match spi_core.
- CLK_DIV, 8'd2, value written to CLKDIV once after reset.
- RD_CMD, 8'h03, flash read opcode; sent as 8-bit command.
- QUAD, 1'b0, 0: standard read (STATUS.rd); 1: quad read (STATUS.qrd).
- DUMMY_CYC, 16'd0, dummy_rd field written to SPIDUM.
- CS_SEL, 2, index of the chip select to assert; csreg = one-hot of CS_SEL.
- POLL_LIMIT, 4096, maximum STATUS polls before a timeout.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  synchronous active-low reset, sampled on the rising edge of HCLK.
- req_valid  in  1  read request valid.
- req_ready  out  1  bridge can accept a request.
- req_addr  in  24  flash byte address; bits [1:0] are ignored and forced to 0.
- resp_valid  out  1  response valid.
- resp_ready  in  1  consumer accepts the response.
- resp_data  out  32  RXFIFO word, passed unmodified.
- resp_err  out  1  qualified by resp_valid; 1 = PSLVERR or poll timeout.
- init_done  out  1  CLKDIV write has completed.
- PADDR  out  APB_ADDR_WIDTH  APB address.
- PWDATA  out  32  APB write data.
- PWRITE  out  1  APB write strobe.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Behaviour:
- Register map of the target (spi_core, word offsets):
  - STATUS 0x00: write [0] rd, [2] qrd, [4] swrst, [11:8] csreg; read [23:16] rx elements, [0] ctrl idle.
  - CLKDIV 0x04; SPICMD 0x08; SPIADR 0x0C.
  - SPILEN 0x10: [5:0] cmd_len, [13:8] addr_len, [31:16] data_len.
  - SPIDUM 0x14: [15:0] dummy_rd.
  - RXFIFO 0x20.
- Reset:
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready, resp_valid, resp_err, init_done all 0; resp_data 0; state INIT.
  - Reset mid-transfer abandons the APB access immediately, with no completion cycle.
- APB engine:
  - Each access is SETUP (PSEL=1, PENABLE=0) for exactly 1 cycle, then ACCESS (PSEL=1, PENABLE=1).
  - ACCESS holds until PREADY=1.
  - PADDR, PWDATA and PWRITE are stable from SETUP through completion.
  - Next access earliest starts the cycle after completion, so an access takes at least 2 cycles.
  - PSLVERR is sampled on the completion cycle only.
- FSM states: INIT, IDLE, W_CMD, W_ADR, W_LEN, W_DUM, W_GO, POLL, RD_RX, RESP.
  - INIT: write CLK_DIV to CLKDIV; on completion init_done=1 (sticky), go to IDLE. A PSLVERR here is ignored.
  - IDLE: req_ready=1. On req_valid & req_ready, latch {req_addr[23:2], 2'b00} and go to W_CMD. req_ready=0 in every other state.
  - W_CMD: SPICMD = {RD_CMD, 24'h0}.
  - W_ADR: SPIADR = {latched_addr, 8'h00}, left-aligned.
  - W_LEN: SPILEN = {16'd32, 2'b0, 6'd24, 2'b0, 6'd8}.
  - W_DUM: SPIDUM = {16'h0, DUMMY_CYC}.
  - W_GO: STATUS = {20'h0, csreg, 3'b0, 1'b0, 1'b0, QUAD, 1'b0, ~QUAD}.
  - POLL: repeated APB reads of STATUS. If PRDATA[23:16] != 0, go to RD_RX. Otherwise increment poll_cnt; when poll_cnt reaches POLL_LIMIT-1 without data, set resp_err=1, resp_data=0, go to RESP. poll_cnt clears on entry to W_CMD.
  - RD_RX: APB read of RXFIFO; resp_data <= PRDATA, resp_err <= PSLVERR; go to RESP.
  - Any PSLVERR during W_CMD..POLL: abort the sequence, resp_err=1, resp_data=0, go to RESP.
  - RESP: resp_valid=1 with resp_data and resp_err stable until resp_ready. The cycle after the handshake: resp_valid=0, go to IDLE.
- Throughput: one outstanding request; no pipelining.
- Minimum latency from request acceptance to resp_valid is 14 cycles (7 accesses × 2) with a zero-wait slave and data present on the first poll.
- resp_valid never asserts outside RESP; req_valid during a busy state is held off by req_ready=0, never dropped.

Test Plan:
- Reset release with PREADY tied high → one write PADDR=0x004, PWDATA=0x02; init_done=1 at cycle 3; no further APB activity while req_valid=0.
- req_addr=0x012347, CS_SEL=2, QUAD=0 → writes in order: 0x008=0x03000000, 0x00C=0x01234400, 0x010=0x00201808, 0x014=0x00000000, 0x000=0x00000401. STATUS reads return 0x00010001, so the RXFIFO read returns 0xDEADBEEF → resp_data=0xDEADBEEF, resp_err=0.
- Slave inserts 3 wait states on every access → PADDR/PWDATA held stable; response still correct; total latency 14+7×3 cycles.
- STATUS rx elements always 0, POLL_LIMIT=8 → exactly 8 STATUS reads, then resp_valid=1, resp_err=1, resp_data=0.
- PSLVERR on the SPIADR write → no SPILEN, SPIDUM or STATUS accesses follow; resp_err=1. resp_ready held low 5 cycles → resp_valid held 5+ cycles; next req accepted 1 cycle after the handshake.
- HRESETn low during the ACCESS phase of the W_GO write → next edge PSEL=0, PENABLE=0, resp_valid=0; after release the INIT CLKDIV write repeats.
